// File: rtl/arp_pkg.sv
// rtl/arp_pkg.sv - shared widths, special IPs and request FSM encoding for the ARP cache
package arp_pkg;

  localparam int IP_W  = 32;
  localparam int MAC_W = 48;

  localparam logic [IP_W-1:0] IP_ZERO  = 32'h0000_0000;
  localparam logic [IP_W-1:0] IP_BCAST = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    R_IDLE  = 2'd0,
    R_ISSUE = 2'd1,
    R_WAIT  = 2'd2
  } req_state_e;

  // Addresses that must never be learned into the cache.
  function automatic logic ip_is_special(input logic [IP_W-1:0] ip);
    return (ip == IP_ZERO) || (ip == IP_BCAST);
  endfunction

endpackage

// File: rtl/arp_cache_victim_sel.sv
// rtl/arp_cache_victim_sel.sv - picks the lowest free slot and the oldest slot of the ARP cache
module arp_cache_victim_sel #(
  parameter int P_DEPTH = 8,
  parameter int P_AGE_W = 8,
  parameter int P_FIRST = 0
) (
  input  logic [P_DEPTH-1:0]              i_valid,
  input  logic [P_DEPTH-1:0][P_AGE_W-1:0] i_age,
  output logic [$clog2(P_DEPTH)-1:0]      o_free_idx,
  output logic [$clog2(P_DEPTH)-1:0]      o_oldest_idx,
  output logic                            o_full
);

  localparam int IW = $clog2(P_DEPTH);

  logic [P_AGE_W-1:0] best_age;

  // Free scan runs downward so the lowest invalid index is written last;
  // oldest scan uses strict '>' so the lowest index wins on equal ages.
  always_comb begin
    o_free_idx   = IW'(P_FIRST);
    o_oldest_idx = IW'(P_FIRST);
    best_age     = i_age[P_FIRST];
    o_full       = &i_valid;
    for (int i = P_DEPTH - 1; i >= P_FIRST; i--) begin
      if (!i_valid[i]) o_free_idx = IW'(i);
    end
    for (int i = P_FIRST + 1; i < P_DEPTH; i++) begin
      if (i_age[i] > best_age) begin
        best_age     = i_age[i];
        o_oldest_idx = IW'(i);
      end
    end
  end

endmodule

// File: rtl/arp_cache_ctrl.sv
// rtl/arp_cache_ctrl.sv - multi-entry ARP cache with aging, eviction and request retries (optional ARP_STATIC_ENTRY_EN)
module arp_cache_ctrl
  import arp_pkg::*;
#(
  parameter int          P_DEPTH       = 8,
  parameter int          P_AGE_W       = 8,
  parameter int          P_AGE_MAX     = 200,
  parameter int          P_RETRY_MAX   = 3,
  parameter int          P_RETRY_TICKS = 2,
  parameter logic [31:0] P_STATIC_IP   = {8'd192, 8'd168, 8'd10, 8'd0},
  parameter logic [47:0] P_STATIC_MAC  = 48'hFF_FF_FF_FF_FF_FF
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [31:0]              i_seek_ip,
  input  logic                     i_seek_valid,
  output logic [47:0]              o_tab_dst_mac,
  output logic                     o_tab_dst_valid,
  output logic                     o_tab_hit,
  input  logic [31:0]              i_updata_ip,
  input  logic [47:0]              i_updata_mac,
  input  logic                     i_updata_valid,
  input  logic                     i_age_tick,
  output logic [31:0]              o_req_ip,
  output logic                     o_req_valid,
  input  logic                     i_req_ready,
  output logic                     o_req_fail,
  output logic [$clog2(P_DEPTH):0] o_entry_count
);

`ifdef ARP_STATIC_ENTRY_EN
  localparam bit STATIC_EN = 1'b1;
`else
  localparam bit STATIC_EN = 1'b0;
`endif
  localparam int FIRST = STATIC_EN ? 1 : 0;
  localparam int IW    = $clog2(P_DEPTH);
  localparam int CW    = IW + 1;
  localparam int TCW   = $clog2(P_RETRY_TICKS + 1);
  localparam int RCW   = $clog2(P_RETRY_MAX + 2);

  // Input stage
  logic             upd_accept;
  logic             upd_valid_q;
  logic [IP_W-1:0]  upd_ip_q;
  logic [MAC_W-1:0] upd_mac_q;
  logic             tick_q;
  logic             seek_valid_q;
  logic [IP_W-1:0]  seek_ip_q;

  // Table
  logic [P_DEPTH-1:0]              valid_q, valid_d;
  logic [P_DEPTH-1:0][IP_W-1:0]    ip_q, ip_d;
  logic [P_DEPTH-1:0][MAC_W-1:0]   mac_q, mac_d;
  logic [P_DEPTH-1:0][P_AGE_W-1:0] age_q, age_d;
  logic [IW-1:0]                   free_idx, oldest_idx, upd_idx, wr_idx;
  logic                            full, upd_hit;

  // Lookup result and occupancy
  logic             seek_hit;
  logic [MAC_W-1:0] seek_mac;
  logic             res_valid_q, res_hit_q;
  logic [MAC_W-1:0] res_mac_q;
  logic [IP_W-1:0]  res_ip_q;
  logic [CW-1:0]    count_d, count_q;

  // Request FSM
  req_state_e      state_q, state_d;
  logic [IP_W-1:0] req_ip_q, req_ip_d;
  logic [RCW-1:0]  retry_q, retry_d;
  logic [TCW-1:0]  tcnt_q, tcnt_d;
  logic            fail_q, fail_d;
  logic            reply;

  assign upd_accept = i_updata_valid && !ip_is_special(i_updata_ip)
                      && !(STATIC_EN && (i_updata_ip == P_STATIC_IP));

  // Lookups and table writes are both registered here, so a lookup in the
  // same cycle as an update compares against the table before the write.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      upd_valid_q  <= 1'b0;
      upd_ip_q     <= '0;
      upd_mac_q    <= '0;
      tick_q       <= 1'b0;
      seek_valid_q <= 1'b0;
      seek_ip_q    <= '0;
    end else begin
      upd_valid_q  <= upd_accept;
      upd_ip_q     <= i_updata_ip;
      upd_mac_q    <= i_updata_mac;
      tick_q       <= i_age_tick;
      seek_valid_q <= i_seek_valid;
      seek_ip_q    <= i_seek_ip;
    end
  end

  arp_cache_victim_sel #(
    .P_DEPTH (P_DEPTH),
    .P_AGE_W (P_AGE_W),
    .P_FIRST (FIRST)
  ) u_victim_sel (
    .i_valid      (valid_q),
    .i_age        (age_q),
    .o_free_idx   (free_idx),
    .o_oldest_idx (oldest_idx),
    .o_full       (full)
  );

  // Dedupe: locate an existing entry for the incoming IP (lowest index).
  always_comb begin
    upd_hit = 1'b0;
    upd_idx = '0;
    for (int i = P_DEPTH - 1; i >= 0; i--) begin
      if (valid_q[i] && (ip_q[i] == upd_ip_q)) begin
        upd_hit = 1'b1;
        upd_idx = IW'(i);
      end
    end
  end

  assign wr_idx = upd_hit ? upd_idx : (full ? oldest_idx : free_idx);

  // Age dynamic entries on a tick, expire them at the limit, then apply the
  // update last so it wins over a coincident tick on the same slot.
  always_comb begin
    valid_d = valid_q;
    ip_d    = ip_q;
    mac_d   = mac_q;
    age_d   = age_q;
    if (tick_q) begin
      for (int i = FIRST; i < P_DEPTH; i++) begin
        if (valid_q[i]) begin
          if (age_q[i] != '1) age_d[i] = age_q[i] + 1'b1;
          if (age_d[i] >= P_AGE_W'(P_AGE_MAX)) begin
            valid_d[i] = 1'b0;
            age_d[i]   = '0;
          end
        end
      end
    end
    if (upd_valid_q) begin
      valid_d[wr_idx] = 1'b1;
      ip_d[wr_idx]    = upd_ip_q;
      mac_d[wr_idx]   = upd_mac_q;
      age_d[wr_idx]   = '0;
    end
  end

  // Table storage; entry 0 comes out of reset holding the static binding when enabled.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      valid_q    <= '0;
      ip_q       <= '0;
      mac_q      <= '0;
      age_q      <= '0;
      valid_q[0] <= STATIC_EN;
      ip_q[0]    <= STATIC_EN ? P_STATIC_IP : IP_ZERO;
      mac_q[0]   <= STATIC_EN ? P_STATIC_MAC : '0;
    end else begin
      valid_q <= valid_d;
      ip_q    <= ip_d;
      mac_q   <= mac_d;
      age_q   <= age_d;
    end
  end

  // Parallel compare of the registered seek IP plus occupancy count.
  always_comb begin
    seek_hit = 1'b0;
    seek_mac = '0;
    count_d  = '0;
    for (int i = P_DEPTH - 1; i >= 0; i--) begin
      if (valid_q[i] && (ip_q[i] == seek_ip_q)) begin
        seek_hit = 1'b1;
        seek_mac = mac_q[i];
      end
      count_d = count_d + CW'(valid_q[i]);
    end
  end

  // Result stage: lands two cycles after the seek strobe.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      res_valid_q <= 1'b0;
      res_hit_q   <= 1'b0;
      res_mac_q   <= '0;
      res_ip_q    <= '0;
      count_q     <= '0;
    end else begin
      res_valid_q <= seek_valid_q;
      res_hit_q   <= seek_valid_q && seek_hit;
      res_mac_q   <= (seek_valid_q && seek_hit) ? seek_mac : '0;
      res_ip_q    <= seek_ip_q;
      count_q     <= count_d;
    end
  end

  assign reply = upd_valid_q && (upd_ip_q == req_ip_q);

  // Request FSM next state: issue, wait a number of ticks, retry or give up.
  always_comb begin
    state_d  = state_q;
    req_ip_d = req_ip_q;
    retry_d  = retry_q;
    tcnt_d   = tcnt_q;
    fail_d   = 1'b0;
    case (state_q)
      R_IDLE: begin
        if (res_valid_q && !res_hit_q) begin
          req_ip_d = res_ip_q;
          retry_d  = '0;
          state_d  = R_ISSUE;
        end
      end
      R_ISSUE: begin
        if (reply) begin
          state_d = R_IDLE;
        end else if (i_req_ready) begin
          tcnt_d  = '0;
          state_d = R_WAIT;
        end
      end
      R_WAIT: begin
        if (reply) begin
          state_d = R_IDLE;
        end else if (i_age_tick) begin
          if (tcnt_q == TCW'(P_RETRY_TICKS - 1)) begin
            if (retry_q < RCW'(P_RETRY_MAX)) begin
              retry_d = retry_q + 1'b1;
              state_d = R_ISSUE;
            end else begin
              fail_d  = 1'b1;
              state_d = R_IDLE;
            end
          end else begin
            tcnt_d = tcnt_q + 1'b1;
          end
        end
      end
      default: state_d = R_IDLE;
    endcase
  end

  // Request FSM state and its registered companions.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state_q  <= R_IDLE;
      req_ip_q <= '0;
      retry_q  <= '0;
      tcnt_q   <= '0;
      fail_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      req_ip_q <= req_ip_d;
      retry_q  <= retry_d;
      tcnt_q   <= tcnt_d;
      fail_q   <= fail_d;
    end
  end

  assign o_tab_dst_valid = res_valid_q;
  assign o_tab_hit       = res_hit_q;
  assign o_tab_dst_mac   = res_mac_q;
  assign o_req_valid     = (state_q == R_ISSUE);
  assign o_req_ip        = req_ip_q;
  assign o_req_fail      = fail_q;
  assign o_entry_count   = count_q;

endmodule

// File: tb/tb_arp_cache_ctrl.sv
// tb/tb_arp_cache_ctrl.sv - scoreboard bench for arp_cache_ctrl against a table-level reference model
module tb_arp_cache_ctrl;

  localparam int DEPTH   = 8;
  localparam int AGE_MAX = 200;

  logic        clk = 1'b0;
  logic        i_rst;
  logic [31:0] i_seek_ip;
  logic        i_seek_valid;
  logic [47:0] o_tab_dst_mac;
  logic        o_tab_dst_valid;
  logic        o_tab_hit;
  logic [31:0] i_updata_ip;
  logic [47:0] i_updata_mac;
  logic        i_updata_valid;
  logic        i_age_tick;
  logic [31:0] o_req_ip;
  logic        o_req_valid;
  logic        i_req_ready;
  logic        o_req_fail;
  logic [3:0]  o_entry_count;

  always #5 clk = ~clk;

  arp_cache_ctrl dut (
    .i_clk           (clk),
    .i_rst           (i_rst),
    .i_seek_ip       (i_seek_ip),
    .i_seek_valid    (i_seek_valid),
    .o_tab_dst_mac   (o_tab_dst_mac),
    .o_tab_dst_valid (o_tab_dst_valid),
    .o_tab_hit       (o_tab_hit),
    .i_updata_ip     (i_updata_ip),
    .i_updata_mac    (i_updata_mac),
    .i_updata_valid  (i_updata_valid),
    .i_age_tick      (i_age_tick),
    .o_req_ip        (o_req_ip),
    .o_req_valid     (o_req_valid),
    .i_req_ready     (i_req_ready),
    .o_req_fail      (o_req_fail),
    .o_entry_count   (o_entry_count)
  );

  typedef struct {
    bit          hit;
    logic [47:0] mac;
    int          due;
  } exp_t;

  exp_t sb_q[$];
  int   n_total = 0;
  int   n_pass  = 0;
  int   cyc     = 0;
  int   hs_cnt  = 0;
  int   fail_cnt = 0;

  // Reference table: a flat list of bindings with ages.
  bit          m_valid[DEPTH];
  logic [31:0] m_ip[DEPTH];
  logic [47:0] m_mac[DEPTH];
  int          m_age[DEPTH];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (o_req_valid && i_req_ready) hs_cnt++;
    if (o_req_fail) fail_cnt++;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic void model_reset();
    for (int i = 0; i < DEPTH; i++) begin
      m_valid[i] = 1'b0;
      m_ip[i]    = '0;
      m_mac[i]   = '0;
      m_age[i]   = 0;
    end
  endfunction

  function automatic int model_count();
    int n = 0;
    for (int i = 0; i < DEPTH; i++) if (m_valid[i]) n++;
    return n;
  endfunction

  function automatic void model_lookup(input logic [31:0] ip, output bit hit, output logic [47:0] mac);
    hit = 1'b0;
    mac = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (m_valid[i] && m_ip[i] == ip) begin
        hit = 1'b1;
        mac = m_mac[i];
        break;
      end
    end
  endfunction

  // One cycle of table events: choose the update slot on the current table,
  // age everything on a tick, then write the update (it beats the tick).
  function automatic void model_step(input bit uv, input logic [31:0] uip, input logic [47:0] umac, input bit tk);
    int tgt = -1;
    if (uv && uip != 32'h0 && uip != 32'hFFFF_FFFF) begin
      for (int i = 0; i < DEPTH; i++)
        if (m_valid[i] && m_ip[i] == uip) begin tgt = i; break; end
      if (tgt < 0)
        for (int i = 0; i < DEPTH; i++)
          if (!m_valid[i]) begin tgt = i; break; end
      if (tgt < 0) begin
        tgt = 0;
        for (int i = 1; i < DEPTH; i++) if (m_age[i] > m_age[tgt]) tgt = i;
      end
    end
    if (tk) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (m_valid[i]) begin
          if (m_age[i] < 255) m_age[i]++;
          if (m_age[i] >= AGE_MAX) begin m_valid[i] = 1'b0; m_age[i] = 0; end
        end
      end
    end
    if (tgt >= 0) begin
      m_valid[tgt] = 1'b1;
      m_ip[tgt]    = uip;
      m_mac[tgt]   = umac;
      m_age[tgt]   = 0;
    end
  endfunction

  task automatic lookup_monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (o_tab_dst_valid) begin
        if (sb_q.size() == 0) begin
          chk("result_expected", 64'(o_tab_dst_valid), 64'd0);
        end else begin
          e = sb_q.pop_front();
          chk("result_cycle", 64'(cyc), 64'(e.due));
          chk("result_hit", 64'(o_tab_hit), 64'(e.hit));
          chk("result_mac", 64'(o_tab_dst_mac), 64'(e.mac));
        end
      end else if (sb_q.size() != 0 && sb_q[0].due < cyc) begin
        chk("result_present", 64'(o_tab_dst_valid), 64'd1);
        void'(sb_q.pop_front());
      end
    end
  endtask

  task automatic drive(input bit sv, input logic [31:0] sip, input bit uv,
                       input logic [31:0] uip, input logic [47:0] umac, input bit tk);
    exp_t        e;
    bit          h;
    logic [47:0] m;
    i_seek_valid   = sv;
    i_seek_ip      = sip;
    i_updata_valid = uv;
    i_updata_ip    = uip;
    i_updata_mac   = umac;
    i_age_tick     = tk;
    if (sv) begin
      model_lookup(sip, h, m);
      e.hit = h;
      e.mac = m;
      e.due = cyc + 2;
      sb_q.push_back(e);
    end
    model_step(uv, uip, umac, tk);
    @(posedge clk);
    #1;
    i_seek_valid   = 1'b0;
    i_updata_valid = 1'b0;
    i_age_tick     = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 32'h0, 1'b0, 32'h0, 48'h0, 1'b0);
  endtask

  task automatic do_reset();
    i_rst = 1'b0;
    @(posedge clk);
    #1;
    sb_q.delete();
    model_reset();
    i_rst = 1'b1;
  endtask

  task automatic wait_req(input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (o_req_valid) begin ok = 1'b1; break; end
      idle(1);
    end
    chk(name, 64'(o_req_valid), 64'd1);
  endtask

  initial begin
    int          hs0, f0;
    bit          ok;
    logic [31:0] uip;

    fork
      lookup_monitor();
    join_none

    i_rst = 1'b0;
    i_seek_ip = '0; i_seek_valid = 1'b0;
    i_updata_ip = '0; i_updata_mac = '0; i_updata_valid = 1'b0;
    i_age_tick = 1'b0; i_req_ready = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tab_valid", 64'(o_tab_dst_valid), 64'd0);
    chk("rst_tab_hit", 64'(o_tab_hit), 64'd0);
    chk("rst_tab_mac", 64'(o_tab_dst_mac), 64'd0);
    chk("rst_req_valid", 64'(o_req_valid), 64'd0);
    chk("rst_req_ip", 64'(o_req_ip), 64'd0);
    chk("rst_req_fail", 64'(o_req_fail), 64'd0);
    chk("rst_count", 64'(o_entry_count), 64'd0);
    i_rst = 1'b1;
    idle(2);

    // Learn then look up one cycle later.
    drive(1'b0, 32'h0, 1'b1, 32'hC0A8_0A05, 48'h1122_3344_5566, 1'b0);
    drive(1'b1, 32'hC0A8_0A05, 1'b0, 32'h0, 48'h0, 1'b0);
    idle(3);
    chk("count_one", 64'(o_entry_count), 64'd1);

    // Miss raises a request that holds until ready; a reply ends it.
    drive(1'b1, 32'hC0A8_0A09, 1'b0, 32'h0, 48'h0, 1'b0);
    wait_req("miss_req_valid");
    chk("miss_req_ip", 64'(o_req_ip), 64'hC0A8_0A09);
    for (int i = 0; i < 5; i++) begin
      idle(1);
      chk("req_hold", 64'(o_req_valid), 64'd1);
    end
    hs0 = hs_cnt; f0 = fail_cnt;
    i_req_ready = 1'b1;
    idle(1);
    i_req_ready = 1'b0;
    chk("req_handshake", 64'(hs_cnt - hs0), 64'd1);
    chk("req_in_wait", 64'(o_req_valid), 64'd0);
    drive(1'b0, 32'h0, 1'b1, 32'hC0A8_0A09, 48'hAABB_CCDD_EEFF, 1'b0);
    for (int i = 0; i < 40; i++) drive(1'b0, 32'h0, 1'b0, 32'h0, 48'h0, (i % 5) == 4);
    chk("reply_no_retry", 64'(hs_cnt - hs0), 64'd1);
    chk("reply_no_fail", 64'(fail_cnt - f0), 64'd0);

    // No reply: 1 + 3 requests, then a single fail pulse.
    do_reset();
    i_req_ready = 1'b1;
    hs0 = hs_cnt; f0 = fail_cnt;
    drive(1'b1, 32'hC0A8_0A4D, 1'b0, 32'h0, 48'h0, 1'b0);
    for (int i = 0; i < 150; i++) drive(1'b0, 32'h0, 1'b0, 32'h0, 48'h0, (i % 10) == 9);
    chk("retry_requests", 64'(hs_cnt - hs0), 64'd4);
    chk("retry_fail_pulse", 64'(fail_cnt - f0), 64'd1);
    chk("retry_idle", 64'(o_req_valid), 64'd0);

    // Reply during the wait ends the sequence without a failure.
    hs0 = hs_cnt; f0 = fail_cnt;
    drive(1'b1, 32'hC0A8_0A4E, 1'b0, 32'h0, 48'h0, 1'b0);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (hs_cnt - hs0 >= 1) begin ok = 1'b1; break; end
      idle(1);
    end
    chk("wait_first_req", 64'(ok), 64'd1);
    idle(3);
    drive(1'b0, 32'h0, 1'b1, 32'hC0A8_0A4E, 48'h0102_0304_0506, 1'b0);
    for (int i = 0; i < 100; i++) drive(1'b0, 32'h0, 1'b0, 32'h0, 48'h0, (i % 10) == 9);
    chk("wait_reply_requests", 64'(hs_cnt - hs0), 64'd1);
    chk("wait_reply_no_fail", 64'(fail_cnt - f0), 64'd0);
    i_req_ready = 1'b0;

    // Full table: oldest (lowest index on tie) is evicted.
    do_reset();
    for (int i = 0; i < 8; i++)
      drive(1'b0, 32'h0, 1'b1, 32'h0A00_0001 + 32'(i), 48'h0000_0000_1000 + 48'(i), 1'b0);
    idle(3);
    chk("fill_count", 64'(o_entry_count), 64'd8);
    drive(1'b0, 32'h0, 1'b0, 32'h0, 48'h0, 1'b1);
    drive(1'b0, 32'h0, 1'b1, 32'h0A00_0004, 48'h0000_0000_2004, 1'b0);
    drive(1'b0, 32'h0, 1'b1, 32'h0A00_0009, 48'h0000_0000_2009, 1'b0);
    idle(3);
    chk("evict_count", 64'(o_entry_count), 64'd8);
    drive(1'b1, 32'h0A00_0001, 1'b0, 32'h0, 48'h0, 1'b0);
    drive(1'b1, 32'h0A00_0004, 1'b0, 32'h0, 48'h0, 1'b0);
    drive(1'b1, 32'h0A00_0009, 1'b0, 32'h0, 48'h0, 1'b0);
    drive(1'b1, 32'h0A00_0002, 1'b0, 32'h0, 48'h0, 1'b0);
    idle(4);

    // Age-out at the limit, and an update on the limit tick keeps the entry.
    do_reset();
    drive(1'b0, 32'h0, 1'b1, 32'h0A01_0101, 48'h0000_0000_0A0A, 1'b0);
    for (int i = 0; i < AGE_MAX - 1; i++) drive(1'b0, 32'h0, 1'b0, 32'h0, 48'h0, 1'b1);
    idle(3);
    chk("age_before_limit", 64'(o_entry_count), 64'd1);
    drive(1'b1, 32'h0A01_0101, 1'b0, 32'h0, 48'h0, 1'b0);
    drive(1'b0, 32'h0, 1'b0, 32'h0, 48'h0, 1'b1);
    idle(3);
    chk("age_expired", 64'(o_entry_count), 64'd0);
    drive(1'b1, 32'h0A01_0101, 1'b0, 32'h0, 48'h0, 1'b0);
    drive(1'b0, 32'h0, 1'b1, 32'h0A01_0102, 48'h0000_0000_0B0B, 1'b0);
    for (int i = 0; i < AGE_MAX - 1; i++) drive(1'b0, 32'h0, 1'b0, 32'h0, 48'h0, 1'b1);
    drive(1'b0, 32'h0, 1'b1, 32'h0A01_0102, 48'h0000_0000_0C0C, 1'b1);
    idle(3);
    chk("age_update_wins", 64'(o_entry_count), 64'd1);
    drive(1'b1, 32'h0A01_0102, 1'b0, 32'h0, 48'h0, 1'b0);
    idle(4);

    // Same-cycle update + seek misses; next cycle hits. Then reset mid-wait.
    do_reset();
    drive(1'b1, 32'hC0A8_0A32, 1'b1, 32'hC0A8_0A32, 48'h0000_0000_3232, 1'b0);
    drive(1'b1, 32'hC0A8_0A32, 1'b0, 32'h0, 48'h0, 1'b0);
    wait_req("sc_req_valid");
    i_req_ready = 1'b1;
    idle(1);
    i_req_ready = 1'b0;
    chk("sc_in_wait", 64'(o_req_valid), 64'd0);
    drive(1'b1, 32'hC0A8_0A33, 1'b0, 32'h0, 48'h0, 1'b0);
    hs0 = hs_cnt; f0 = fail_cnt;
    do_reset();
    chk("mid_rst_req_valid", 64'(o_req_valid), 64'd0);
    chk("mid_rst_req_ip", 64'(o_req_ip), 64'd0);
    chk("mid_rst_tab_valid", 64'(o_tab_dst_valid), 64'd0);
    chk("mid_rst_count", 64'(o_entry_count), 64'd0);
    for (int i = 0; i < 40; i++) drive(1'b0, 32'h0, 1'b0, 32'h0, 48'h0, (i % 5) == 4);
    chk("mid_rst_no_fail", 64'(fail_cnt - f0), 64'd0);
    chk("mid_rst_no_req", 64'(hs_cnt - hs0), 64'd0);
    chk("mid_rst_idle", 64'(o_req_valid), 64'd0);

    // Randomized traffic over a small IP pool to exercise dedupe and eviction.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      uip = 32'h0A00_0100 + 32'($urandom_range(1, 12));
      if ($urandom_range(0, 15) == 0) uip = ($urandom_range(0, 1) == 1) ? 32'hFFFF_FFFF : 32'h0;
      drive($urandom_range(0, 1) == 1, 32'h0A00_0100 + 32'($urandom_range(1, 12)),
            $urandom_range(0, 2) == 0, uip, 48'($urandom()) << 8 | 48'(i),
            $urandom_range(0, 7) == 0);
    end
    idle(4);
    chk("random_count", 64'(o_entry_count), 64'(model_count()));
    chk("scoreboard_drained", 64'(sb_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
